rom_loader: RTL and testbench

- Write-side counterpart to the instruction ROM: receives a program image as a byte stream and writes it, word by word, into instruction RAM through a synchronous write port.
- Holds the CPU in reset until a complete image has been written.
- Sits between the host byte receiver (e.g. a UART RX valid/ready stream) and the code memory write port.

---
 rtl/rom_loader.sv | 135 +++++++++++++
 tb/tb_rom_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// Byte-stream program loader: SYNC, count, little-endian words -> code RAM; holds CPU in reset until done.
// Word write 1 cycle after its last byte; in_ready low only in WRITE. ROM_LOADER_CHECKSUM_EN adds a trailing checksum byte.
module rom_loader #(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

`ifdef ROM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, CSUM, DONE} state_t;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, DONE} state_t;
`endif

  state_t                state;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [BCW-1:0]        byte_cnt;
  logic                  accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      last_addr <= '0;
      byte_cnt  <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // A sync byte restarts a load from either resting state; anything else is dropped.
          if (accept && in_data == SYNC_BYTE) begin
            state     <= COUNT;
            error     <= 1'b0;
            done      <= 1'b0;
            cpu_reset <= 1'b1;
            busy      <= 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
          end
        end
        COUNT: begin
          if (accept) begin
            last_addr <= ADDR_WIDTH'(in_data);
            mem_addr  <= '0;
            byte_cnt  <= '0;
            state     <= DATA;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum      <= csum + in_data;
`endif
          end
        end
        DATA: begin
          if (accept) begin
            mem_data[byte_cnt*8 +: 8] <= in_data;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum <= csum + in_data;
`endif
            if (byte_cnt == BCW'(BYTES - 1)) begin
              byte_cnt <= '0;
              state    <= WRITE;
              mem_we   <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          in_ready <= 1'b1;
          if (mem_addr == last_addr) begin
`ifdef ROM_LOADER_CHECKSUM_EN
            state     <= CSUM;
`else
            state     <= DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
            busy      <= 1'b0;
`endif
          end else begin
            mem_addr <= mem_addr + 1'b1;
            state    <= DATA;
          end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            busy <= 1'b0;
            if (in_data == csum) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              // Image already in RAM stays; CPU stays in reset until a clean reload.
              state <= IDLE;
              error <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: expected writes queued as bytes are driven, checked as mem_we fires.
module tb_rom_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  rom_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [39:0] exp_q[$];
  logic [31:0] img[256];
  logic [7:0]  tb_sum;
  bit          gaps = 1'b0;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      check("in_ready_only_low_in_write", 40'(in_ready), 40'(!mem_we));
      if (mem_we) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_write observed=%h expected=none", {mem_addr, mem_data});
        end
        if (exp_q.size() != 0) check("write_addr_data", {mem_addr, mem_data}, exp_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gaps && $urandom_range(1, 0) == 1) begin
      in_data = 8'($urandom);
      repeat ($urandom_range(3, 1)) @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    tb_sum   = tb_sum + b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=in_ready_low expected=accept");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load(input int n, input bit bad_sum, input bit skip_sync);
    logic [7:0] s;
    if (!skip_sync) send_byte(8'hA5);
    tb_sum = 8'h00;
    send_byte(8'(n - 1));
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'(i), img[i]});
      for (int k = 0; k < 4; k++) send_byte(img[i][8*k +: 8]);
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    s = bad_sum ? tb_sum + 8'h01 : tb_sum;
    send_byte(s);
`else
    s = 8'h00;
`endif
  endtask

  // Call right after load(); checks completion timing relative to the final byte.
  task automatic expect_done(input string tag);
`ifdef ROM_LOADER_CHECKSUM_EN
    check({tag, "_done"}, 40'(done), 40'(1));
    check({tag, "_cpu_reset"}, 40'(cpu_reset), 40'(0));
    @(negedge clk);
`else
    check({tag, "_done_t1"}, 40'(done), 40'(0));
    check({tag, "_cpu_reset_t1"}, 40'(cpu_reset), 40'(1));
    @(negedge clk);
    check({tag, "_done_t2"}, 40'(done), 40'(1));
    check({tag, "_cpu_reset_t2"}, 40'(cpu_reset), 40'(0));
`endif
    check({tag, "_busy"}, 40'(busy), 40'(0));
    check({tag, "_error"}, 40'(error), 40'(0));
    @(negedge clk);
    check({tag, "_pending_writes"}, 40'(exp_q.size()), 40'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 40'(in_ready), 40'(1));
    check({tag, "_mem_we"}, 40'(mem_we), 40'(0));
    check({tag, "_mem_addr"}, 40'(mem_addr), 40'(0));
    check({tag, "_mem_data"}, 40'(mem_data), 40'(0));
    check({tag, "_cpu_reset"}, 40'(cpu_reset), 40'(1));
    check({tag, "_busy"}, 40'(busy), 40'(0));
    check({tag, "_done"}, 40'(done), 40'(0));
    check({tag, "_error"}, 40'(error), 40'(0));
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tb_sum   = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_values("reset");

    // Two-word image.
    img[0] = 32'h00000001;
    img[1] = 32'h00000003;
    load(2, 1'b0, 1'b0);
    expect_done("two_word");

    // Junk before sync is ignored, then a single word.
    send_byte(8'h00);
    send_byte(8'hFF);
    check("junk_busy", 40'(busy), 40'(0));
    check("junk_done_held", 40'(done), 40'(1));
    img[0] = 32'h20000040;
    load(1, 1'b0, 1'b0);
    expect_done("one_word");

    // Full 256-word image; last address must be 255 with no extra write.
    for (int i = 0; i < 256; i++) img[i] = 32'(i);
    load(256, 1'b0, 1'b0);
    expect_done("full");
    check("full_last_addr", 40'(mem_addr), 40'(8'hFF));

    // Random valid gaps over a 4-word load.
    for (int i = 0; i < 4; i++) img[i] = $urandom;
    gaps = 1'b1;
    load(4, 1'b0, 1'b0);
    gaps = 1'b0;
    expect_done("gaps");

    // Abort after 6 data bytes: word 0 is legitimately written, word 1 never is.
    img[0] = 32'h44332211;
    send_byte(8'hA5);
    send_byte(8'h01);
    exp_q.push_back({8'h00, img[0]});
    for (int k = 0; k < 6; k++) send_byte(8'h11 * 8'(k + 1));
    check("abort_busy", 40'(busy), 40'(1));
    check("abort_cpu_reset", 40'(cpu_reset), 40'(1));
    reset = 1'b1;
    #1;
    check("abort_async_busy", 40'(busy), 40'(0));
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("abort");
    repeat (3) @(negedge clk);
    check("abort_pending", 40'(exp_q.size()), 40'(0));
    img[0] = 32'hDEADBEEF;
    load(1, 1'b0, 1'b0);
    expect_done("after_abort");

`ifdef ROM_LOADER_CHECKSUM_EN
    img[0] = 32'h04030201;
    load(1, 1'b0, 1'b0);
    expect_done("csum_ok");
    load(1, 1'b1, 1'b0);
    @(negedge clk);
    check("csum_bad_error", 40'(error), 40'(1));
    check("csum_bad_cpu_reset", 40'(cpu_reset), 40'(1));
    check("csum_bad_done", 40'(done), 40'(0));
    check("csum_bad_busy", 40'(busy), 40'(0));
    check("csum_bad_pending", 40'(exp_q.size()), 40'(0));
    send_byte(8'hA5);
    check("csum_sync_clears_error", 40'(error), 40'(0));
    check("csum_sync_busy", 40'(busy), 40'(1));
    load(1, 1'b0, 1'b1);
    expect_done("csum_reload");
`else
    check("no_csum_error_tied", 40'(error), 40'(0));
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
